multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Five-state sequencer that drives the MIPS datapath in multi-cycle mode: fetch, decode, execute, memory, write-back. Decodes Op/Funct from the instruction register for the supported set: addu, subu, jr, sra, ori, lui, lw, lb, lbu, lh, lhu, sw, sb, sh, beq, j, jal. Per cycle it produces:
- the write enables (PC, IR, register file, data memory)
- the next-PC select
- memory request strobes with an optional ready handshake
- a retired-instruction count

It sits beside the combinational field decoder, which still supplies ALUctr, ExtOp, MemtoReg, RegDst and the load/store selects.

## Interface
- RETIRE_W, 32, width of retired-instruction counter

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  IR[31:26], valid from DECODE onward
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU compare result for beq, valid in EXEC
- imem_ack  in  1  instruction memory ready
- dmem_ack  in  1  data memory ready
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory access request
- MemWr  out  1  data memory write enable
- IRWr  out  1  load IR
- PCWr  out  1  load PC
- pc_src  out  2  00 PC+4, 01 branch target, 10 jr (rs), 11 j/jal target
- RegWr  out  1  register file write enable
- state  out  3  current state encoding
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on unsupported encoding
- retired  out  RETIRE_W  retired-instruction count

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are unreachable; if entered, the next state is FETCH.
- All outputs except state and retired are combinational from state, Op, Funct, Zero and the acks.
- **FETCH**
  - imem_req=1.
  - On ack: IRWr=1, PCWr=1, pc_src=00, go to DECODE.
  - Without ack: hold, with IRWr=PCWr=0.
- **DECODE**
  - j: PCWr=1, pc_src=11, go to FETCH, retire.
  - jr: PCWr=1, pc_src=10, go to FETCH, retire.
  - jal: PCWr=1, pc_src=11, go to WB.
  - Unsupported Op, or Op=0 with unsupported Funct: illegal=1, go to FETCH, no retire.
  - Otherwise go to EXEC.
- **EXEC**
  - beq: PCWr=Zero, pc_src=01, go to FETCH, retire.
  - Loads and stores: go to MEM.
  - Others: go to WB.
- **MEM**
  - dmem_req=1. Stores also drive MemWr=1 for the whole stay in MEM.
  - On ack: stores go to FETCH and retire; loads go to WB.
- **WB**
  - RegWr=1 for exactly one cycle, go to FETCH, retire.
  - This also performs jal's $ra write.
- Retire means: instr_done=1 in that cycle, and retired increments at the clock edge, wrapping from all-ones to 0.
- RegWr, MemWr and PCWr are never asserted outside the states listed above.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=FETCH, retired=0.
  - All strobes are 0 while reset is held, including imem_req.
  - FETCH requests begin in the first cycle after release.
- Reset mid-access: the request drops immediately; a late ack after release is ignored unless the block is in the matching state.
- Cycles per instruction with zero-wait memory:
  - addu/subu/sra/ori/lui: 4
  - loads: 5
  - stores: 4
  - beq: 3
  - j/jr: 2
  - jal: 3
  - illegal: 2
- Each wait cycle on a handshake adds 1 cycle. imem_req and dmem_req stay high until the ack cycle.
- An ack is sampled only in the state that owns it. dmem_ack seen in FETCH has no effect, and vice versa.

## Configuration
- MCTRL_MEM_HANDSHAKE_EN
  - Defined: FETCH and MEM wait on imem_ack/dmem_ack as described above.
  - Undefined: both acks are treated as constant 1, FETCH and MEM always last exactly one cycle, and the ack inputs remain as ports but are unused.

## Test plan
- Reset release, then addu with acks tied high → state sequence 0,1,2,4,0. RegWr high only in cycle 4. instr_done pulses once. retired=1.
- lw with dmem_ack delayed 3 cycles (macro defined) → MEM held 4 cycles with dmem_req=1 and MemWr=0, then WB. Total 8 cycles.
- sw → MemWr=1 throughout MEM, no RegWr, retire on ack. 4 cycles.
- beq with Zero=1, then beq with Zero=0 → PCWr=1 with pc_src=01 in the first case, PCWr=0 in the second. Each takes 3 cycles.
- jal, then Op=6'b111111 → jal: PCWr and pc_src=11 in DECODE, RegWr in WB. 6'b111111: illegal pulse, retired unchanged.
- rst_n asserted low while in MEM waiting for an ack → outputs drop to 0 asynchronously, retired=0, restart in FETCH. Preload retired to 0xFFFFFFFF and retire one instruction → retired wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state sequencer (FETCH, DECODE, EXEC, MEM, WB) for
// the multi-cycle MIPS datapath. It produces the PC/IR/register-file/memory
// write enables, the next-PC select and the memory request strobes, and it
// keeps a count of retired instructions.
//
// Optional feature macro: MCTRL_MEM_HANDSHAKE_EN
//   defined   - FETCH waits for imem_ack and MEM waits for dmem_ack
//   undefined - both acks are treated as 1; FETCH and MEM last one cycle each
module multicycle_ctrl #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          Op,
  input  logic [5:0]          Funct,
  input  logic                Zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                MemWr,
  output logic                IRWr,
  output logic                PCWr,
  output logic [1:0]          pc_src,
  output logic                RegWr,
  output logic [2:0]          state,
  output logic                instr_done,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // Opcode values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function values
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  state_e                state_q, state_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;

  logic                  imem_ok_s;
  logic                  dmem_ok_s;

  logic                  is_legal_s;
  logic                  is_load_s;
  logic                  is_store_s;
  logic                  is_beq_s;
  logic                  is_j_s;
  logic                  is_jal_s;
  logic                  is_jr_s;

`ifdef MCTRL_MEM_HANDSHAKE_EN
  assign imem_ok_s = imem_ack;
  assign dmem_ok_s = dmem_ack;
`else
  // Acks are ignored in this build; memories are assumed to answer in one cycle.
  logic unused_acks_s;
  assign unused_acks_s = imem_ack ^ dmem_ack;
  assign imem_ok_s     = 1'b1;
  assign dmem_ok_s     = 1'b1;
`endif

  // Classify the instruction held in IR into the classes the sequencer needs.
  always_comb begin
    is_legal_s = 1'b0;
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    is_beq_s   = 1'b0;
    is_j_s     = 1'b0;
    is_jal_s   = 1'b0;
    is_jr_s    = 1'b0;
    case (Op)
      OP_RTYPE: begin
        case (Funct)
          FN_ADDU, FN_SUBU, FN_SRA: is_legal_s = 1'b1;
          FN_JR: begin
            is_legal_s = 1'b1;
            is_jr_s    = 1'b1;
          end
          default: is_legal_s = 1'b0;
        endcase
      end
      OP_J: begin
        is_legal_s = 1'b1;
        is_j_s     = 1'b1;
      end
      OP_JAL: begin
        is_legal_s = 1'b1;
        is_jal_s   = 1'b1;
      end
      OP_BEQ: begin
        is_legal_s = 1'b1;
        is_beq_s   = 1'b1;
      end
      OP_ORI, OP_LUI: is_legal_s = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        is_legal_s = 1'b1;
        is_load_s  = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        is_legal_s = 1'b1;
        is_store_s = 1'b1;
      end
      default: is_legal_s = 1'b0;
    endcase
  end

  // Next-state and per-cycle strobes; everything is forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    MemWr      = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    pc_src     = PC_PLUS4;
    RegWr      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ok_s) begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          if (!is_legal_s) begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end else if (is_j_s) begin
            PCWr       = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (is_jr_s) begin
            PCWr       = 1'b1;
            pc_src     = PC_JR;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (is_jal_s) begin
            // PC takes the jump target now; $ra is written in WB.
            PCWr    = 1'b1;
            pc_src  = PC_JUMP;
            state_d = S_WB;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_beq_s) begin
            PCWr       = Zero;
            pc_src     = PC_BRANCH;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (is_load_s || is_store_s) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          MemWr    = is_store_s;
          if (dmem_ok_s) begin
            if (is_store_s) begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else begin
            state_d = S_MEM;
          end
        end
        S_WB: begin
          RegWr      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      state_d = S_FETCH;
    end
  end

  // Retire counter advances on every retirement and wraps naturally.
  always_comb begin
    if (instr_done) begin
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  // State and retire-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= {RETIRE_W{1'b0}};
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. A second instance with a 2-bit retire
// counter shares all inputs so counter wrap-around can be observed quickly.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req, dmem_req, MemWr, IRWr, PCWr, RegWr;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        instr_done, illegal;
  logic [31:0] retired;

  logic        w_imem_req, w_dmem_req, w_MemWr, w_IRWr, w_PCWr, w_RegWr;
  logic [1:0]  w_pc_src;
  logic [2:0]  w_state;
  logic        w_instr_done, w_illegal;
  logic [1:0]  w_retired;

  int total = 0;
  int bad   = 0;

  logic [12:0] e_f, e_fw, e_d, e_x, e_wb, e_ld, e_st;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .MemWr(MemWr), .IRWr(IRWr),
    .PCWr(PCWr), .pc_src(pc_src), .RegWr(RegWr), .state(state),
    .instr_done(instr_done), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl #(.RETIRE_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(w_imem_req), .dmem_req(w_dmem_req), .MemWr(w_MemWr), .IRWr(w_IRWr),
    .PCWr(w_PCWr), .pc_src(w_pc_src), .RegWr(w_RegWr), .state(w_state),
    .instr_done(w_instr_done), .illegal(w_illegal), .retired(w_retired)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected strobe vector: {state, imem_req, dmem_req, MemWr, IRWr, PCWr, pc_src, RegWr, instr_done, illegal}
  function automatic logic [12:0] ev(input logic [2:0] st, input logic ireq, input logic dreq,
                                     input logic mw, input logic irw, input logic pcw,
                                     input logic [1:0] pcs, input logic rw, input logic done,
                                     input logic ill);
    return {st, ireq, dreq, mw, irw, pcw, pcs, rw, done, ill};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {state, imem_req, dmem_req, MemWr, IRWr, PCWr, pc_src, RegWr, instr_done, illegal};
  endfunction

  // Called at a falling edge: settle, compare one cycle, move to the next falling edge.
  task automatic cyc(input string tag, input logic [12:0] exp);
    #1;
    check_val(tag, {19'd0, obs_vec()}, {19'd0, exp});
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    Op    = op;
    Funct = fn;
  endtask

  initial begin
    e_f  = ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    e_fw = ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    e_d  = ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    e_x  = ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    e_wb = ev(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    e_ld = ev(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    e_st = ev(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

    rst_n    = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    Zero     = 1'b0;
    set_instr(6'h00, 6'h21);

    // Reset held: every strobe low even with imem_ack high
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("rst_outputs", {19'd0, obs_vec()}, 32'd0);
    check_val("rst_retired", retired, 32'd0);
    rst_n = 1'b1;

    // addu: 0,1,2,4
    cyc("addu_fetch", e_f);
    cyc("addu_dec", e_d);
    cyc("addu_exec", e_x);
    cyc("addu_wb", e_wb);
    #1 check_val("addu_retired", retired, 32'd1);

    // lw with dmem_ack held off for 3 MEM cycles
    set_instr(6'h23, 6'h00);
    dmem_ack = 1'b0;
    cyc("lw_fetch", e_f);
    cyc("lw_dec", e_d);
    cyc("lw_exec", e_x);
`ifdef MCTRL_MEM_HANDSHAKE_EN
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", e_ld);
`endif
    dmem_ack = 1'b1;
    cyc("lw_mem_ack", e_ld);
    cyc("lw_wb", e_wb);
    #1 check_val("lw_retired", retired, 32'd2);

    // sw, fetch stalled on imem_ack first (handshake build only)
    set_instr(6'h2B, 6'h00);
`ifdef MCTRL_MEM_HANDSHAKE_EN
    imem_ack = 1'b0;
    cyc("sw_fetch_wait", e_fw);
    cyc("sw_fetch_wait", e_fw);
    imem_ack = 1'b1;
    cyc("sw_fetch", e_f);
`else
    imem_ack = 1'b0;
    cyc("sw_fetch_noack", e_f);
    imem_ack = 1'b1;
`endif
    cyc("sw_dec", e_d);
    cyc("sw_exec", e_x);
    cyc("sw_mem", e_st);
    #1 check_val("sw_retired", retired, 32'd3);
    check_val("wrap_allones", {30'd0, w_retired}, 32'd3);

    // beq taken then not taken
    set_instr(6'h04, 6'h00);
    Zero = 1'b1;
    cyc("beq1_fetch", e_f);
    cyc("beq1_dec", e_d);
    cyc("beq1_exec", ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0));
    #1 check_val("beq1_retired", retired, 32'd4);
    check_val("wrap_zero", {30'd0, w_retired}, 32'd0);
    Zero = 1'b0;
    cyc("beq0_fetch", e_f);
    cyc("beq0_dec", e_d);
    cyc("beq0_exec", ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0));

    // j and jr retire from DECODE
    set_instr(6'h02, 6'h00);
    cyc("j_fetch", e_f);
    cyc("j_dec", ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0));
    set_instr(6'h00, 6'h08);
    cyc("jr_fetch", e_f);
    cyc("jr_dec", ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0));
    #1 check_val("jr_retired", retired, 32'd7);

    // jal: jump in DECODE, $ra write in WB
    set_instr(6'h03, 6'h00);
    cyc("jal_fetch", e_f);
    cyc("jal_dec", ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0));
    cyc("jal_wb", e_wb);

    // Illegal opcode and illegal R-type funct
    set_instr(6'h3F, 6'h00);
    cyc("ill_op_fetch", e_f);
    cyc("ill_op_dec", ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
    set_instr(6'h00, 6'h20);
    cyc("ill_fn_fetch", e_f);
    cyc("ill_fn_dec", ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
    #1 check_val("ill_retired", retired, 32'd8);

    // ori and lhu
    set_instr(6'h0D, 6'h00);
    cyc("ori_fetch", e_f);
    cyc("ori_dec", e_d);
    cyc("ori_exec", e_x);
    cyc("ori_wb", e_wb);
    set_instr(6'h25, 6'h00);
    cyc("lhu_fetch", e_f);
    cyc("lhu_dec", e_d);
    cyc("lhu_exec", e_x);
    cyc("lhu_mem", e_ld);
    cyc("lhu_wb", e_wb);
    #1 check_val("lhu_retired", retired, 32'd10);

    // Reset asserted while in MEM waiting on dmem_ack
    set_instr(6'h23, 6'h00);
    dmem_ack = 1'b0;
    cyc("rl_fetch", e_f);
    cyc("rl_dec", e_d);
    cyc("rl_exec", e_x);
    #1 check_val("rl_mem", {19'd0, obs_vec()}, {19'd0, e_ld});
    #1 rst_n = 1'b0;
    #1 check_val("rl_async_out", {19'd0, obs_vec()}, 32'd0);
    check_val("rl_async_ret", retired, 32'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_instr(6'h00, 6'h23);
    cyc("post_rst_fetch", e_f);
    cyc("post_rst_dec", e_d);
    cyc("post_rst_exec", e_x);
    cyc("post_rst_wb", e_wb);
    #1 check_val("post_rst_retired", retired, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
